// File: rtl/adder_delay_timer_if.sv
// Bundle between the delay timer and its controller / instrumented adder chain.
// Controller-side modport is master, timer-side modport is slave.
interface adder_delay_timer_if #(
   parameter int CNT_W = 32
);
   // start and clear are single-cycle requests sampled on the rising clock
   // edge. They are acted on only in the state where they are meaningful and
   // are silently dropped elsewhere. There is no ready or back-pressure.
   logic             active;
   logic             start;
   logic             clear;
   logic [CNT_W-1:0] max_count;
   logic             chain_out;
   logic             chain_in;
   logic [CNT_W-1:0] count;
   logic             busy;
   logic             done;
   logic             timeout;

   modport master (
      output active, start, clear, max_count, chain_out,
      input  chain_in, count, busy, done, timeout
   );

   modport slave (
      input  active, start, clear, max_count, chain_out,
      output chain_in, count, busy, done, timeout
   );
endinterface

// File: rtl/adder_delay_timer.sv
// Measures adder-chain propagation delay in wb_clk_i cycles, bounded by max_count.
// Define DELAY_TIMER_SYNC_EN to add a synchronizer stage on chain_out (+1 cycle).
module adder_delay_timer #(
   parameter int CNT_W = 32
) (
   input  logic                 wb_clk_i,
   input  logic                 wb_rst_i,
   adder_delay_timer_if.slave   bus,
   output logic [1:0]           dbg_state_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q;
   logic [CNT_W-1:0] count_q;
   logic             timeout_q;
   logic             chain_in_q;
   logic             chain_q;
   logic             chain_prev_q;
   logic             rise;

`ifdef DELAY_TIMER_SYNC_EN
   // chain_out is asynchronous: meta_q is the first synchronizer stage and
   // chain_q doubles as the second.
   logic meta_q;

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         meta_q       <= 1'b0;
         chain_q      <= 1'b0;
         chain_prev_q <= 1'b0;
      end else begin
         meta_q       <= bus.chain_out;
         chain_q      <= meta_q;
         chain_prev_q <= chain_q;
      end
   end
`else
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         chain_q      <= 1'b0;
         chain_prev_q <= 1'b0;
      end else begin
         chain_q      <= bus.chain_out;
         chain_prev_q <= chain_q;
      end
   end
`endif

   assign rise = chain_q & ~chain_prev_q;

   // A rise seen in the same cycle the limit is reached takes priority, so a
   // chain finishing exactly at max_count still reports a valid result.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q    <= IDLE;
         count_q    <= '0;
         timeout_q  <= 1'b0;
         chain_in_q <= 1'b0;
      end else if (!bus.active) begin
         state_q    <= IDLE;
         chain_in_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.start) begin
                  state_q    <= RUN;
                  count_q    <= '0;
                  timeout_q  <= 1'b0;
                  chain_in_q <= 1'b1;
               end
            end
            RUN: begin
               if (rise) begin
                  state_q    <= DONE;
                  timeout_q  <= 1'b0;
                  chain_in_q <= 1'b0;
               end else if (count_q == bus.max_count) begin
                  state_q    <= DONE;
                  count_q    <= bus.max_count;
                  timeout_q  <= 1'b1;
                  chain_in_q <= 1'b0;
               end else begin
                  count_q <= count_q + 1'b1;
               end
            end
            DONE: begin
               if (bus.clear) begin
                  state_q <= IDLE;
               end
            end
            default: begin
               state_q    <= IDLE;
               chain_in_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.chain_in = chain_in_q;
   assign bus.count    = count_q;
   assign bus.timeout  = timeout_q;
   assign bus.busy     = (state_q == RUN);
   assign bus.done     = (state_q == DONE);
   assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_adder_delay_timer.sv
// Self-checking bench for adder_delay_timer with a behavioural adder-chain model.
// Honors DELAY_TIMER_SYNC_EN for the expected detection latency.
module tb_adder_delay_timer;

   localparam int CNT_W = 32;
`ifdef DELAY_TIMER_SYNC_EN
   localparam int LAT = 1;
`else
   localparam int LAT = 0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] dbg_state;
   logic       chain_out_m = 1'b0;
   int         chain_delay = -1;
   int         chain_cnt   = 0;

   int n_checks = 0;
   int n_pass   = 0;

   logic [CNT_W:0]   exp_q[$];
   logic [CNT_W-1:0] last_count;

   adder_delay_timer_if #(.CNT_W(CNT_W)) bus ();

   adder_delay_timer #(.CNT_W(CNT_W)) dut (
      .wb_clk_i    (clk),
      .wb_rst_i    (rst),
      .bus         (bus),
      .dbg_state_o (dbg_state)
   );

   always #5 clk = ~clk;

   assign bus.chain_out = chain_out_m;

   // Chain model: output rises so that the chain_delay-th edge after
   // chain_in rises is the first to sample it high.
   always @(negedge clk) begin
      if (bus.chain_in) begin
         chain_cnt = chain_cnt + 1;
         if (chain_delay > 0 && chain_cnt >= chain_delay) chain_out_m = 1'b1;
      end else begin
         chain_cnt   = 0;
         chain_out_m = 1'b0;
      end
   end

   task automatic chk(input string name, input logic [CNT_W-1:0] got, input logic [CNT_W-1:0] want);
      n_checks++;
      if (got !== want) $display("FAIL %s: got %0d expected %0d", name, got, want);
      else n_pass++;
   endtask

   task automatic pulse_start();
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic wait_done(output bit got, output int runs);
      got  = 1'b0;
      runs = 0;
      for (int i = 0; i < 2000; i++) begin
         if (bus.done) begin
            got = 1'b1;
            break;
         end
         if (bus.busy) runs++;
         @(negedge clk);
      end
   endtask

   task automatic run_measure(input int mx, input int dly);
      int             exp_cnt;
      bit             exp_to;
      bit             got;
      int             runs;
      logic [CNT_W:0] e;
      bus.max_count = CNT_W'(mx);
      chain_delay   = dly;
      if (dly > 0 && dly + LAT <= mx) begin
         exp_cnt = dly + LAT;
         exp_to  = 1'b0;
      end else begin
         exp_cnt = mx;
         exp_to  = 1'b1;
      end
      exp_q.push_back({exp_to, CNT_W'(exp_cnt)});
      pulse_start();
      chk("run_busy", CNT_W'(bus.busy), 1);
      chk("run_chain_in", CNT_W'(bus.chain_in), 1);
      wait_done(got, runs);
      chk("done_seen", CNT_W'(got), 1);
      if (got) begin
         e = exp_q.pop_front();
         last_count = e[CNT_W-1:0];
         chk("result_count", bus.count, e[CNT_W-1:0]);
         chk("result_timeout", CNT_W'(bus.timeout), CNT_W'(e[CNT_W]));
         chk("run_cycles", CNT_W'(runs), CNT_W'(exp_cnt + 1));
         chk("done_chain_in", CNT_W'(bus.chain_in), 0);
      end
   endtask

   task automatic do_clear();
      bus.clear = 1'b1;
      @(negedge clk);
      bus.clear = 1'b0;
      chk("clear_done", CNT_W'(bus.done), 0);
      chk("clear_busy", CNT_W'(bus.busy), 0);
      chk("clear_count_hold", bus.count, last_count);
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      chk("rst_count", bus.count, 0);
      chk("rst_busy", CNT_W'(bus.busy), 0);
      chk("rst_done", CNT_W'(bus.done), 0);
      chk("rst_chain_in", CNT_W'(bus.chain_in), 0);
      chk("rst_timeout", CNT_W'(bus.timeout), 0);
      chk("rst_state", CNT_W'(dbg_state), 0);
   endtask

   task automatic test_measure();
      run_measure(100, 10);
      do_clear();
   endtask

   task automatic test_timeout();
      run_measure(20, -1);
      do_clear();
   endtask

   task automatic test_zero_max();
      run_measure(0, -1);
      do_clear();
   endtask

   task automatic test_tie();
      run_measure(8, 8 - LAT);
      do_clear();
   endtask

   task automatic test_ignore();
      bit got;
      int runs;
      logic [CNT_W:0] e;
      bus.max_count = 100;
      chain_delay   = 6;
      exp_q.push_back({1'b0, CNT_W'(6 + LAT)});
      pulse_start();
      repeat (2) @(negedge clk);
      pulse_start();
      bus.clear = 1'b1;
      @(negedge clk);
      bus.clear = 1'b0;
      chk("ign_run_busy", CNT_W'(bus.busy), 1);
      wait_done(got, runs);
      chk("ign_done_seen", CNT_W'(got), 1);
      e = exp_q.pop_front();
      chk("ign_count", bus.count, e[CNT_W-1:0]);
      pulse_start();
      @(negedge clk);
      chk("ign_start_in_done", CNT_W'(bus.done), 1);
      chk("ign_count_in_done", bus.count, e[CNT_W-1:0]);
      bus.start = 1'b1;
      bus.clear = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      bus.clear = 1'b0;
      chk("both_done", CNT_W'(bus.done), 0);
      chk("both_busy", CNT_W'(bus.busy), 0);
      @(negedge clk);
      chk("both_stay_idle", CNT_W'(dbg_state), 0);
      chk("both_count_hold", bus.count, e[CNT_W-1:0]);
      repeat (2) @(negedge clk);
   endtask

   task automatic test_abort();
      int  seen_done;
      bus.max_count = 100;
      chain_delay   = -1;
      pulse_start();
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rstrun_busy", CNT_W'(bus.busy), 0);
      chk("rstrun_chain_in", CNT_W'(bus.chain_in), 0);
      chk("rstrun_done", CNT_W'(bus.done), 0);
      chk("rstrun_count", bus.count, 0);
      seen_done = 0;
      repeat (5) begin
         @(negedge clk);
         if (bus.done) seen_done++;
      end
      chk("rstrun_no_done", CNT_W'(seen_done), 0);
      pulse_start();
      repeat (4) @(negedge clk);
      bus.active = 1'b0;
      @(negedge clk);
      chk("inact_busy", CNT_W'(bus.busy), 0);
      chk("inact_chain_in", CNT_W'(bus.chain_in), 0);
      chk("inact_done", CNT_W'(bus.done), 0);
      chk("inact_count_hold", bus.count, 4);
      pulse_start();
      @(negedge clk);
      chk("inact_start_ignored", CNT_W'(bus.busy), 0);
      bus.active = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_random();
      for (int i = 0; i < 6; i++) begin
         run_measure(int'($urandom_range(30, 2)), int'($urandom_range(35, 1)));
         do_clear();
      end
   endtask

   initial begin
      bus.active    = 1'b1;
      bus.start     = 1'b0;
      bus.clear     = 1'b0;
      bus.max_count = '0;
      last_count    = '0;
      test_reset();
      test_measure();
      test_timeout();
      test_zero_max();
      test_tie();
      test_ignore();
      test_abort();
      test_random();
      chk("scoreboard_empty", CNT_W'(exp_q.size()), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/adder_delay_timer.md
ADDER_DELAY_TIMER -- requirements
Module: adder_delay_timer

Interface
REQ-001 SHALL have parameter: CNT_W, 32, width of the delay counter and limit (8..32).
REQ-002 SHALL have port: wb_clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port: wb_rst_i  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: active  input  1  design select; 0 forces the FSM to IDLE.
REQ-005 SHALL have port: start  input  1  one-cycle request to launch a measurement.
REQ-006 SHALL have port: clear  input  1  acknowledge a result; DONE -> IDLE.
REQ-007 SHALL have port: max_count  input  CNT_W  timeout limit in clock cycles.
REQ-008 SHALL have port: chain_out  input  1  completion output of the upstream instrumented adder chain, asynchronous to wb_clk_i.
REQ-009 SHALL have port: chain_in  output  1  launch signal driven into the adder chain.
REQ-010 SHALL have port: count  output  CNT_W  measured delay in clock cycles.
REQ-011 SHALL have port: busy  output  1  high in RUN.
REQ-012 SHALL have port: done  output  1  high in DONE.
REQ-013 SHALL have port: timeout  output  1  high when the last result ended at max_count.

Function
REQ-014 SHALL implement FSM states IDLE, RUN and DONE, fully registered.
REQ-015 IDLE: when start=1 and active=1, SHALL go to RUN next cycle, clear count to 0 and clear timeout to 0.
REQ-016 RUN: chain_in SHALL be 1 (registered); in every other state it SHALL be 0.
REQ-017 chain_out SHALL be sampled into chain_q; rise detected when chain_q=1 and its previous value=0.
REQ-018 RUN, rise detected: SHALL go to DONE; count frozen (no increment that cycle); timeout=0.
REQ-019 RUN, no rise, count==max_count: SHALL go to DONE; count=max_count; timeout=1.
REQ-020 RUN, otherwise: count SHALL increment by 1; no wrap possible since max_count bounds it.
REQ-021 Simultaneous rise and count==max_count: rise SHALL win (timeout=0).
REQ-022 max_count=0: SHALL enter DONE after one RUN cycle, count=0, timeout=1 unless rise seen.
REQ-023 start in RUN or DONE SHALL be ignored; clear in IDLE or RUN SHALL be ignored.
REQ-024 DONE: clear=1 SHALL go to IDLE; count and timeout SHALL hold until the next start.
REQ-025 DONE: start=1 with clear=0 SHALL be ignored; start and clear together SHALL go to IDLE only.
REQ-026 active=0 in any state SHALL force IDLE next cycle (chain_in=0, busy=0, done=0); count and timeout hold.
REQ-027 busy and done SHALL decode directly from state registers (no extra latency).

Reset
REQ-028 wb_rst_i=1 at a clock edge SHALL set state=IDLE, count=0, timeout=0, chain_in=0, all sync/edge flops=0, overriding all inputs.
REQ-029 Reset mid-RUN SHALL abort the measurement with no DONE pulse.

Configuration
REQ-030 Macro DELAY_TIMER_SYNC_EN defined: chain_out SHALL pass through a 2-flop synchronizer before chain_q (one extra cycle of detection latency).
REQ-031 Macro undefined: chain_out SHALL be sampled by a single flop into chain_q; no other behaviour change.
REQ-032 Result for a chain with D-cycle delay (D = clock edges from chain_in rise to first edge sampling chain_out=1) SHALL be D without the macro, D+1 with it.

Verification
REQ-033 Reset, then idle 5 cycles -> count=0, busy=0, done=0, chain_in=0, timeout=0.
REQ-034 max_count=100, start, chain_out rises 10 cycles after chain_in -> done=1, count=10 (macro off) / 11 (macro on), timeout=0.
REQ-035 max_count=20, chain_out held 0 -> done=1 after 21 RUN cycles, count=20, timeout=1.
REQ-036 max_count=0, start -> done after one RUN cycle, count=0, timeout=1.
REQ-037 Start mid-RUN and start in DONE -> ignored, count unchanged; clear in DONE -> IDLE, count holds.
REQ-038 wb_rst_i pulsed (or active=0) mid-RUN -> IDLE next cycle, chain_in=0, no done; reset also zeroes count.
